// File: rtl/counter_call_scheduler_if.sv
// Bus bundle for the five-counter ticket scheduler: ticket/done strobes in,
// call display, per-counter status and queue status out.
interface counter_call_scheduler_if;
  logic       button;
  logic [4:0] counter_done;
  logic [5:0] current_number;
  logic [5:0] number_service;
  logic [3:0] counter_call;
  logic       call_strobe;
  logic [4:0] counter_busy;
  logic [5:0] A_serviceNumber;
  logic [5:0] B_serviceNumber;
  logic [5:0] C_serviceNumber;
  logic [5:0] D_serviceNumber;
  logic [5:0] E_serviceNumber;
  logic [4:0] waiting;
  logic       queue_full;
  logic       ticket_drop;

  modport master (
    output button, counter_done,
    input  current_number, number_service, counter_call, call_strobe,
           counter_busy, A_serviceNumber, B_serviceNumber, C_serviceNumber,
           D_serviceNumber, E_serviceNumber, waiting, queue_full, ticket_drop
  );

  modport slave (
    input  button, counter_done,
    output current_number, number_service, counter_call, call_strobe,
           counter_busy, A_serviceNumber, B_serviceNumber, C_serviceNumber,
           D_serviceNumber, E_serviceNumber, waiting, queue_full, ticket_drop
  );
endinterface

// File: rtl/counter_call_scheduler.sv
// Ticket-queue scheduler for counters A..E: issues tickets, calls them in order
// to idle counters round-robin. Optional timeout release: define AUTO_RELEASE_EN.
module counter_call_scheduler #(
  parameter int MAX_TICKET     = 63,
  parameter int QUEUE_DEPTH    = 16,
  parameter int CALL_HOLD      = 2,
  parameter int SERVICE_CYCLES = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  counter_call_scheduler_if.slave  bus
);

  localparam int NUM_COUNTERS = 5;
  localparam int HOLD_W       = (CALL_HOLD > 1) ? $clog2(CALL_HOLD) : 1;

  if (CALL_HOLD < 1 || SERVICE_CYCLES < 1 || MAX_TICKET > 63) begin : gBadParams
    $error("counter_call_scheduler: illegal parameter value");
  end

  typedef enum logic {IDLE, HOLD} stateT;

  stateT             state, nextState;
  logic [HOLD_W-1:0] holdCnt, nextHoldCnt;

  logic [5:0] currentNumber;
  logic [5:0] numberService;
  logic [5:0] callNumber;
  logic [3:0] counterCall;
  logic       callStrobe;
  logic       ticketDrop;
  logic [4:0] waitingCnt;
  logic [4:0] busy;
  logic [4:0] free;
  logic [4:0] doneMask;
  logic [4:0] timeoutMask;
  logic [4:0] grantMask;
  logic [2:0] rrPtr;
  logic [2:0] grantIdx;
  logic       grant;
  logic       found;
  logic       queueFull;
  logic       accept;
  logic [5:0] serviceNumber [NUM_COUNTERS];

  function automatic logic [5:0] nextTicket(input logic [5:0] n);
    return (n == 6'(MAX_TICKET)) ? 6'd1 : n + 6'd1;
  endfunction

  assign free       = ~busy;
  assign queueFull  = (waitingCnt == 5'(QUEUE_DEPTH));
  assign accept     = bus.button & ~queueFull;
  assign callNumber = nextTicket(numberService);
  assign grantMask  = grant ? (5'b00001 << grantIdx) : 5'b00000;
  assign doneMask   = (bus.counter_done & busy) | timeoutMask;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make update order change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      holdCnt <= '0;
    end else begin
      state   <= nextState;
      holdCnt <= nextHoldCnt;
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nextState   = state;
    nextHoldCnt = holdCnt;
    grant       = 1'b0;
    grantIdx    = 3'd0;
    found       = 1'b0;
    case (state)
      IDLE: begin
        if (waitingCnt != 5'd0 && free != 5'd0) begin
          // Search rrPtr+1 .. rrPtr, wrapping E -> A; first free counter wins.
          for (int k = 1; k <= NUM_COUNTERS; k++) begin
            int cand;
            cand = (int'(rrPtr) + k) % NUM_COUNTERS;
            if (!found && free[cand]) begin
              found    = 1'b1;
              grantIdx = 3'(cand);
            end
          end
          grant       = found;
          nextState   = HOLD;
          nextHoldCnt = HOLD_W'(CALL_HOLD - 1);
        end
      end
      HOLD: begin
        if (holdCnt == '0) nextState = IDLE;
        else               nextHoldCnt = holdCnt - 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: the per-counter service-number array is reset because its contents
  // drive outputs that must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      currentNumber <= '0;
      numberService <= '0;
      counterCall   <= '0;
      callStrobe    <= 1'b0;
      ticketDrop    <= 1'b0;
      waitingCnt    <= '0;
      busy          <= '0;
      rrPtr         <= 3'd4;
      for (int i = 0; i < NUM_COUNTERS; i++) serviceNumber[i] <= '0;
    end else begin
      callStrobe <= grant;
      ticketDrop <= bus.button & queueFull;
      waitingCnt <= waitingCnt + {4'd0, accept} - {4'd0, grant};
      busy       <= (busy & ~doneMask) | grantMask;
      if (accept) currentNumber <= nextTicket(currentNumber);
      if (grant) begin
        numberService           <= callNumber;
        serviceNumber[grantIdx] <= callNumber;
        counterCall             <= {1'b0, grantIdx} + 4'd1;
        rrPtr                   <= grantIdx;
      end
    end
  end

`ifdef AUTO_RELEASE_EN
  localparam int TMR_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

  logic [TMR_W-1:0] svcTimer [NUM_COUNTERS];

  // Timer is loaded on grant and runs only while busy; reaching zero releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) svcTimer[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (grantMask[i])
          svcTimer[i] <= TMR_W'(SERVICE_CYCLES - 1);
        else if (busy[i] && svcTimer[i] != '0)
          svcTimer[i] <= svcTimer[i] - 1'b1;
      end
    end
  end

  always_comb begin
    timeoutMask = '0;
    for (int i = 0; i < NUM_COUNTERS; i++)
      timeoutMask[i] = busy[i] && (svcTimer[i] == '0);
  end
`else
  assign timeoutMask = '0;
`endif

  assign bus.current_number  = currentNumber;
  assign bus.number_service  = numberService;
  assign bus.counter_call    = counterCall;
  assign bus.call_strobe     = callStrobe;
  assign bus.counter_busy    = busy;
  assign bus.waiting         = waitingCnt;
  assign bus.queue_full      = queueFull;
  assign bus.ticket_drop     = ticketDrop;
  assign bus.A_serviceNumber = serviceNumber[0];
  assign bus.B_serviceNumber = serviceNumber[1];
  assign bus.C_serviceNumber = serviceNumber[2];
  assign bus.D_serviceNumber = serviceNumber[3];
  assign bus.E_serviceNumber = serviceNumber[4];

endmodule
